// File: rtl/unsigned_16by8_div_seq.sv
// Sequential unsigned restoring divider: 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock, valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operand handshake, in_ready high
// BUSY  | iterating, one quotient bit retired per clock
// DONE  | result held, out_valid high until the consumer accepts it
module unsigned_16by8_div_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] x,
    input  logic [DW-1:0]   y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] q,
    output logic [DW-1:0]   r,
    output logic            dbz
);

    localparam int CW = $clog2(2*DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2*DW-1:0] x_sh;
    logic [DW-1:0]   y_reg;
    logic [DW:0]     rem;
    logic [CW-1:0]   cnt;

    logic [DW:0]     rem_sh;
    logic [DW:0]     rem_nxt;
    logic            q_bit;

    // The shifted remainder is always below 2*y, so DW+1 bits never overflow.
    always_comb begin
        rem_sh  = {rem[DW-1:0], x_sh[2*DW-1]};
        q_bit   = (rem_sh >= {1'b0, y_reg});
        rem_nxt = q_bit ? (rem_sh - {1'b0, y_reg}) : rem_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            x_sh      <= '0;
            y_reg     <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sh     <= x;
                        y_reg    <= y;
                        rem      <= '0;
                        cnt      <= CW'(2*DW-1);
                        in_ready <= 1'b0;
                        if (y == '0) begin
                            q         <= '1;
                            r         <= x[DW-1:0];
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            q     <= '0;
                            dbz   <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem  <= rem_nxt;
                    x_sh <= {x_sh[2*DW-2:0], 1'b0};
                    q    <= {q[2*DW-2:0], q_bit};
                    cnt  <= cnt - 1'b1;
                    // Down-counter terminal count marks the last iteration.
                    if (cnt == '0) begin
                        r         <= rem_nxt[DW-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
